// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Frame timing constants and the controller state encoding.
package uart_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int CNT_W_DEF  = 14;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter side bundle of the UART transmit arbiter.
// The arbiter uses the slave view; sources and monitors use master.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);

    logic [9:0]         clks_per_bit;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*8-1:0] data_in;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               busy;
    logic [15:0]        frames_sent;

    modport master (
        output clks_per_bit,
        output req,
        output data_in,
        input  grant,
        input  tx_data,
        input  tx_start,
        input  busy,
        input  frames_sent
    );

    modport slave (
        input  clks_per_bit,
        input  req,
        input  data_in,
        output grant,
        output tx_data,
        output tx_start,
        output busy,
        output frames_sent
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker.
// Search order is ptr..N_REQ-1 then 0..ptr-1; first set request wins.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    int j;

    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                win[j]  = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one busy-less 8N1 transmitter.
// The frame plus guard gap is timed locally by a down-counter.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GUARD_CLKS = 16,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] grant_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             busy_q;
    logic [15:0]      frames_q;

    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic [7:0]       win_byte;
    logic [CNT_W-1:0] frame_last;
    logic [IDX_W-1:0] ptr_next;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_byte = bus.data_in[i*8 +: 8];
        end
    end

    // Counter reload value is the last cycle index of frame plus guard.
    assign frame_last = CNT_W'(bus.clks_per_bit) * CNT_W'(FRAME_BITS)
                      + CNT_W'(GUARD_CLKS) - CNT_W'(1);

    assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0
                                                      : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            frames_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid && bus.clks_per_bit != 10'd0) begin
                        state      <= BUSY;
                        tx_data_q  <= win_byte;
                        tx_start_q <= 1'b1;
                        grant_q    <= win;
                        busy_q     <= 1'b1;
                        cnt        <= frame_last;
                        ptr        <= ptr_next;
                        frames_q   <= frames_q + 16'd1;
                    end
                end
                BUSY: begin
                    tx_start_q <= 1'b0;
                    grant_q    <= '0;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.busy        = busy_q;
    assign bus.frames_sent = frames_q;

endmodule
